// File: rtl/multicycle_core.sv
// Multi-cycle core: FETCH/DECODE/EXECUTE/WRITEBACK over an 8-entry register file,
// with a request/valid instruction port that tolerates any memory latency.
module multicycle_core #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned PC_W   = 10,
  parameter int unsigned RET_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              zero,
  output logic              wb_en,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [RET_W-1:0]  retired
);
  localparam int unsigned NREG = 8;
  localparam int unsigned IW   = 16;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_SUBI = 3'd3;
  localparam logic [2:0] OP_BEQZ = 3'd4;
  localparam logic [2:0] OP_JMP  = 3'd5;
  localparam logic [2:0] OP_LI   = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, npc_q, npc_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
  logic              req_q, req_d, halted_q, halted_d, zero_q, zero_d;
  logic              wb_en_q, wb_en_d;
  logic [2:0]        wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [RET_W-1:0]  ret_q, ret_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];

  logic [2:0]        op, rd, rs1, rs2;
  logic [PC_W-1:0]   pc_inc, br_tgt, jmp_tgt;

  assign op      = ir_q[15:13];
  assign rd      = ir_q[12:10];
  assign rs1     = ir_q[9:7];
  assign rs2     = ir_q[2:0];
  assign pc_inc  = pc_q + PC_W'(1);
  assign br_tgt  = pc_inc + PC_W'({{6{ir_q[6]}}, ir_q[6:0]});
  assign jmp_tgt = PC_W'(ir_q[12:0]);

  // Next-state and datapath; every _d defaults to hold except the one-cycle writeback strobe.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    npc_d     = npc_q;
    ir_d      = ir_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    req_d     = req_q;
    halted_d  = halted_q;
    zero_d    = zero_q;
    ret_d     = ret_q;
    rf_d      = rf_q;
    wb_en_d   = 1'b0;
    wb_addr_d = '0;
    wb_data_d = '0;

    case (state_q)
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          req_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        opa_d   = rf_q[rs1];
        opb_d   = rf_q[rs2];
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = S_WRITEBACK;
        npc_d   = pc_inc;
        case (op)
          OP_ADD: begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd;
            wb_data_d = opa_q + opb_q;
          end
          OP_SUB: begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd;
            wb_data_d = opa_q - opb_q;
          end
          OP_ADDI: begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd;
            wb_data_d = opa_q + DATA_W'(ir_q[3:0]);
          end
          OP_SUBI: begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd;
            wb_data_d = opa_q - DATA_W'(ir_q[3:0]);
          end
          OP_BEQZ: begin
            if (opa_q == '0) npc_d = br_tgt;
          end
          OP_JMP: begin
            npc_d = jmp_tgt;
          end
          OP_LI: begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd;
            wb_data_d = DATA_W'(ir_q[9:0]);
          end
          default: begin
            npc_d = pc_q;
          end
        endcase
      end
      S_WRITEBACK: begin
        if (wb_en_q) begin
          zero_d = (wb_data_q == '0);
          if (wb_addr_q != 3'd0) rf_d[wb_addr_q] = wb_data_q;
        end
        ret_d = ret_q + RET_W'(1);
        pc_d  = npc_q;
        if (op == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        req_d   = 1'b1;
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      npc_q     <= '0;
      ir_q      <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      req_q     <= 1'b1;
      halted_q  <= 1'b0;
      zero_q    <= 1'b0;
      ret_q     <= '0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      rf_q      <= '{default: '0};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      npc_q     <= npc_d;
      ir_q      <= ir_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      req_q     <= req_d;
      halted_q  <= halted_d;
      zero_q    <= zero_d;
      ret_q     <= ret_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      rf_q      <= rf_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign zero      = zero_q;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign retired   = ret_q;
endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: a 16/10-bit instance and a 32/13-bit instance
// (3-bit retire counter) run directed programs against a latency-programmable memory.
module tb_multicycle_core;
  typedef struct packed {
    logic [2:0]  a;
    logic [31:0] d;
  } wb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DATA_W=16, PC_W=10, RET_W=32
  logic        a_rst, a_req, a_valid, a_halted, a_zero, a_wb_en;
  logic [9:0]  a_addr, a_pc;
  logic [15:0] a_rdata, a_wb_data;
  logic [2:0]  a_wb_addr;
  logic [31:0] a_ret;
  // Instance B: DATA_W=32, PC_W=13, RET_W=3
  logic        b_rst, b_req, b_valid, b_halted, b_zero, b_wb_en;
  logic [12:0] b_addr, b_pc;
  logic [15:0] b_rdata;
  logic [31:0] b_wb_data;
  logic [2:0]  b_wb_addr;
  logic [2:0]  b_ret;

  multicycle_core #(.DATA_W(16), .PC_W(10), .RET_W(32)) u_a (
    .clk(clk), .reset(a_rst), .imem_req(a_req), .imem_addr(a_addr), .imem_rdata(a_rdata),
    .imem_valid(a_valid), .pc(a_pc), .halted(a_halted), .zero(a_zero), .wb_en(a_wb_en),
    .wb_addr(a_wb_addr), .wb_data(a_wb_data), .retired(a_ret));

  multicycle_core #(.DATA_W(32), .PC_W(13), .RET_W(3)) u_b (
    .clk(clk), .reset(b_rst), .imem_req(b_req), .imem_addr(b_addr), .imem_rdata(b_rdata),
    .imem_valid(b_valid), .pc(b_pc), .halted(b_halted), .zero(b_zero), .wb_en(b_wb_en),
    .wb_addr(b_wb_addr), .wb_data(b_wb_data), .retired(b_ret));

  // Instruction memory: per-instance wait counter, latency chosen per request
  logic [15:0] mem [0:8191];
  int a_wait = 0, a_lat = 0, b_wait = 0, b_lat = 0;
  bit rand_lat = 1'b0;

  always @(posedge clk) begin
    if (!a_rst) begin
      a_wait <= 0;
      a_lat  <= 0;
    end else if (a_req && a_valid) begin
      a_wait <= 0;
      a_lat  <= rand_lat ? int'($urandom_range(5, 0)) : 0;
    end else if (a_req) begin
      a_wait <= a_wait + 1;
    end
  end

  always @(posedge clk) begin
    if (!b_rst) begin
      b_wait <= 0;
      b_lat  <= 0;
    end else if (b_req && b_valid) begin
      b_wait <= 0;
      b_lat  <= rand_lat ? int'($urandom_range(5, 0)) : 0;
    end else if (b_req) begin
      b_wait <= b_wait + 1;
    end
  end

  assign a_valid = a_rst && a_req && (a_wait >= a_lat);
  assign b_valid = b_rst && b_req && (b_wait >= b_lat);
  assign a_rdata = a_valid ? mem[13'(a_addr)] : 16'hDEAD;
  assign b_rdata = b_valid ? mem[b_addr] : 16'hDEAD;

  // Only one instance runs at a time; sel picks which one the monitor watches
  bit          sel = 1'b0;
  logic        m_rst, m_req, m_valid, m_halted, m_zero, m_wb_en;
  logic [31:0] m_addr, m_pc, m_wb_data, m_ret;
  logic [2:0]  m_wb_addr;

  always_comb begin
    if (sel) begin
      m_rst = b_rst; m_req = b_req; m_valid = b_valid; m_halted = b_halted; m_zero = b_zero;
      m_wb_en = b_wb_en; m_addr = 32'(b_addr); m_pc = 32'(b_pc); m_wb_data = b_wb_data;
      m_ret = 32'(b_ret); m_wb_addr = b_wb_addr;
    end else begin
      m_rst = a_rst; m_req = a_req; m_valid = a_valid; m_halted = a_halted; m_zero = a_zero;
      m_wb_en = a_wb_en; m_addr = 32'(a_addr); m_pc = 32'(a_pc); m_wb_data = 32'(a_wb_data);
      m_ret = a_ret; m_wb_addr = a_wb_addr;
    end
  end

  int n_tot = 0, n_bad = 0, n_acc = 0;
  logic [31:0] fq[$];
  wb_t         wq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tot++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Monitor: pops expected fetches and writebacks as the DUT presents them
  bit          hold = 1'b0, zpend = 1'b0, zexp = 1'b0;
  logic [31:0] addr_prev = '0;
  wb_t         e_w;

  always @(negedge clk) begin
    if (!m_rst) begin
      hold  = 1'b0;
      zpend = 1'b0;
    end else begin
      if (zpend) begin
        chk("zero_flag", 32'(m_zero), 32'(zexp));
        zpend = 1'b0;
      end
      if (hold && m_req) chk("addr_stable", m_addr, addr_prev);
      if (m_req && m_valid) begin
        n_acc++;
        if (fq.size() == 0) chk("fetch_unexpected", m_addr, 32'hFFFF_FFFF);
        else chk("fetch_addr", m_addr, fq.pop_front());
      end
      hold      = m_req && !m_valid;
      addr_prev = m_addr;
      if (m_wb_en) begin
        if (wq.size() == 0) begin
          chk("wb_unexpected", 32'(m_wb_en), 32'd0);
        end else begin
          e_w = wq.pop_front();
          chk("wb_addr", 32'(m_wb_addr), 32'(e_w.a));
          chk("wb_data", m_wb_data, e_w.d);
          zexp  = (e_w.d == 32'd0);
          zpend = 1'b1;
        end
      end
    end
  end

  function automatic logic [15:0] f_r(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, 4'b0000, rs2};
  endfunction
  function automatic logic [15:0] f_i(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [3:0] imm);
    return {op, rd, rs1, 3'b000, imm};
  endfunction
  function automatic logic [15:0] f_beqz(input logic [2:0] rs1, input logic [6:0] off);
    return {3'd4, 3'd0, rs1, off};
  endfunction
  function automatic logic [15:0] f_jmp(input logic [12:0] t);
    return {3'd5, t};
  endfunction
  function automatic logic [15:0] f_li(input logic [2:0] rd, input logic [9:0] imm);
    return {3'd6, rd, imm};
  endfunction
  localparam logic [15:0] HALT = 16'hE000;

  task automatic clear_mem();
    for (int i = 0; i < 8192; i++) mem[i] = HALT;
  endtask

  task automatic exp_w(input logic [2:0] a, input logic [31:0] d);
    wb_t t;
    t.a = a;
    t.d = d;
    wq.push_back(t);
  endtask

  task automatic exp_f(input logic [31:0] adr);
    fq.push_back(adr);
  endtask

  task automatic hold_reset(input bit s);
    a_rst = 1'b0;
    b_rst = 1'b0;
    sel   = s;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", m_pc, 32'd0);
    chk("rst_halted", 32'(m_halted), 32'd0);
    chk("rst_zero", 32'(m_zero), 32'd0);
    chk("rst_wb_en", 32'(m_wb_en), 32'd0);
    chk("rst_wb_addr", 32'(m_wb_addr), 32'd0);
    chk("rst_wb_data", m_wb_data, 32'd0);
    chk("rst_retired", m_ret, 32'd0);
    chk("rst_req", 32'(m_req), 32'd1);
    fq.delete();
    wq.delete();
    n_acc = 0;
  endtask

  task automatic release_rst();
    if (sel) b_rst = 1'b1;
    else a_rst = 1'b1;
  endtask

  task automatic run_to_halt(input int budget);
    int n;
    n = 0;
    while (!m_halted && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("halt_reached", 32'(m_halted), 32'd1);
  endtask

  task automatic fin(input logic [31:0] pc_e, input logic [31:0] ret_e, input bit z_e,
                     input int acc_e);
    @(negedge clk);
    @(negedge clk);
    chk("final_pc", m_pc, pc_e);
    chk("final_retired", m_ret, ret_e);
    chk("final_zero", 32'(m_zero), 32'(z_e));
    chk("final_halted", 32'(m_halted), 32'd1);
    chk("final_req", 32'(m_req), 32'd0);
    chk("fetch_count", 32'(n_acc), 32'(acc_e));
    chk("wb_pending", 32'(wq.size()), 32'd0);
    chk("fetch_pending", 32'(fq.size()), 32'd0);
  endtask

  task automatic load_prog1();
    clear_mem();
    mem[0] = f_li(3'd1, 10'd5);
    mem[1] = f_li(3'd2, 10'd3);
    mem[2] = f_r(3'd0, 3'd3, 3'd1, 3'd2);
    mem[3] = f_r(3'd1, 3'd4, 3'd2, 3'd1);
    mem[4] = HALT;
  endtask

  task automatic exp_prog1();
    for (int i = 0; i < 5; i++) exp_f(32'(i));
    exp_w(3'd1, 32'd5);
    exp_w(3'd2, 32'd3);
    exp_w(3'd3, 32'd8);
    exp_w(3'd4, 32'h0000_FFFE);
  endtask

  initial begin
    a_rst = 1'b0;
    b_rst = 1'b0;

    // Basic program, zero-latency memory, exact halt cycle
    load_prog1();
    rand_lat = 1'b0;
    hold_reset(1'b0);
    exp_prog1();
    release_rst();
    repeat (19) @(posedge clk);
    #1;
    chk("halted_cyc19", 32'(a_halted), 32'd0);
    @(posedge clk);
    #1;
    chk("halted_cyc20", 32'(a_halted), 32'd1);
    fin(32'd4, 32'd5, 1'b0, 5);

    // Same program, random fetch latency
    rand_lat = 1'b1;
    hold_reset(1'b0);
    exp_prog1();
    release_rst();
    run_to_halt(400);
    fin(32'd4, 32'd5, 1'b0, 5);
    rand_lat = 1'b0;

    // Branches, jump to the top of PC space and wrap to 0
    clear_mem();
    mem[0]      = f_i(3'd2, 3'd7, 3'd7, 4'd1);
    mem[1]      = f_i(3'd3, 3'd6, 3'd7, 4'd2);
    mem[2]      = f_beqz(3'd6, 7'd9);
    mem[3]      = f_li(3'd1, 10'd0);
    mem[4]      = f_beqz(3'd1, 7'd2);
    mem[5]      = f_li(3'd3, 10'd1);
    mem[6]      = f_li(3'd3, 10'd2);
    mem[7]      = f_li(3'd2, 10'd7);
    mem[8]      = f_beqz(3'd2, 7'd2);
    mem[9]      = f_jmp(13'h3FF);
    mem[10'h3FF] = f_i(3'd2, 3'd5, 3'd2, 4'd1);
    mem[12]     = HALT;
    hold_reset(1'b0);
    foreach (fq_init_a[i]) exp_f(fq_init_a[i]);
    exp_w(3'd7, 32'd1);
    exp_w(3'd6, 32'h0000_FFFF);
    exp_w(3'd1, 32'd0);
    exp_w(3'd2, 32'd7);
    exp_w(3'd5, 32'd8);
    exp_w(3'd7, 32'd2);
    exp_w(3'd6, 32'd0);
    release_rst();
    run_to_halt(400);
    fin(32'd12, 32'd13, 1'b1, 13);

    // R0 handling and immediates
    clear_mem();
    mem[0] = f_r(3'd0, 3'd6, 3'd0, 3'd0);
    mem[1] = f_i(3'd2, 3'd0, 3'd0, 4'd9);
    mem[2] = f_r(3'd0, 3'd5, 3'd0, 3'd0);
    mem[3] = f_i(3'd3, 3'd5, 3'd0, 4'd1);
    mem[4] = HALT;
    hold_reset(1'b0);
    for (int i = 0; i < 5; i++) exp_f(32'(i));
    exp_w(3'd6, 32'd0);
    exp_w(3'd0, 32'd9);
    exp_w(3'd5, 32'd0);
    exp_w(3'd5, 32'h0000_FFFF);
    release_rst();
    run_to_halt(400);
    fin(32'd4, 32'd5, 1'b0, 5);

    // Reset during EXECUTE of ADD R3,R1,R2 aborts it
    load_prog1();
    hold_reset(1'b0);
    for (int i = 0; i < 3; i++) exp_f(32'(i));
    exp_w(3'd1, 32'd5);
    exp_w(3'd2, 32'd3);
    release_rst();
    repeat (10) @(posedge clk);
    #1;
    a_rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_wb_en", 32'(a_wb_en), 32'd0);
    chk("abort_pc", 32'(a_pc), 32'd0);
    chk("abort_retired", a_ret, 32'd0);
    chk("abort_req", 32'(a_req), 32'd1);
    chk("abort_wb_seen", 32'(wq.size()), 32'd0);
    chk("abort_fetch_seen", 32'(fq.size()), 32'd0);
    mem[0] = f_r(3'd0, 3'd4, 3'd3, 3'd3);
    mem[1] = HALT;
    n_acc  = 0;
    exp_f(32'd0);
    exp_f(32'd1);
    exp_w(3'd4, 32'd0);
    a_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_no_wb", 32'(a_wb_en), 32'd0);
    run_to_halt(400);
    fin(32'd1, 32'd2, 1'b1, 2);

    // Wide instance: 32-bit data, 13-bit PC wrap, 3-bit retire counter wrap
    clear_mem();
    mem[0]      = f_i(3'd2, 3'd7, 3'd7, 4'd1);
    mem[1]      = f_i(3'd3, 3'd6, 3'd7, 4'd2);
    mem[2]      = f_beqz(3'd6, 7'd3);
    mem[3]      = f_li(3'd1, 10'h3FF);
    mem[4]      = f_i(3'd2, 3'd1, 3'd1, 4'd1);
    mem[5]      = f_jmp(13'h1FFF);
    mem[13'h1FFF] = f_li(3'd2, 10'd5);
    mem[6]      = HALT;
    hold_reset(1'b1);
    foreach (fq_init_b[i]) exp_f(fq_init_b[i]);
    exp_w(3'd7, 32'd1);
    exp_w(3'd6, 32'hFFFF_FFFF);
    exp_w(3'd1, 32'h0000_03FF);
    exp_w(3'd1, 32'h0000_0400);
    exp_w(3'd2, 32'd5);
    exp_w(3'd7, 32'd2);
    exp_w(3'd6, 32'd0);
    release_rst();
    run_to_halt(400);
    fin(32'd6, 32'd3, 1'b1, 11);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  // Expected fetch address sequences for the branch programs
  logic [31:0] fq_init_a [13] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd7, 32'd8, 32'd9,
                                  32'h3FF, 32'd0, 32'd1, 32'd2, 32'd12};
  logic [31:0] fq_init_b [11] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'h1FFF,
                                  32'd0, 32'd1, 32'd2, 32'd6};
endmodule
